triangle_assembler: RTL and testbench
=====================================

// Module: triangle_assembler
// PURPOSE
//  Collects a vertex_t stream (valid/ready) into triangles in list, strip or fan topology.
//  Drives triangle_setup: pulses setup_start, then holds setup_v0..v2 stable until setup_done.
//  Sits directly upstream of triangle_setup. Stalls the vertex stream while setup is busy.
// PARAMETERS
//  COUNT_W  16  width of the triangle/drop status counters (wrap-around)
// PORTS
//  clk           in   1        clock; single clock domain
//  rst_n         in   1        asynchronous active-low reset
//  in_vertex     in   vertex_t incoming vertex
//  in_valid      in   1        in_vertex valid
//  in_last       in   1        qualifies in_vertex; last vertex of primitive (restart after it)
//  in_ready      out  1        assembler can accept a vertex
//  mode          in   2        00 list, 01 strip, 10 fan, 11 treated as list
//  setup_v0      out  vertex_t triangle vertex 0 to setup
//  setup_v1      out  vertex_t triangle vertex 1 to setup
//  setup_v2      out  vertex_t triangle vertex 2 to setup
//  setup_start   out  1        one-cycle start pulse to setup
//  setup_busy    in   1        setup busy (state != IDLE)
//  setup_done    in   1        setup completed (one-cycle)
//  tri_count     out  COUNT_W  triangles issued to setup
//  drop_count    out  COUNT_W  vertices discarded as incomplete primitives at in_last
// BEHAVIOUR
//  Reset: state=COLLECT, vcnt=0, parity=0; setup_start=0, in_ready=0 during reset, tri_count=0,
//   drop_count=0, setup_v*='0. Buffer regs A, B, C cleared.
//  Accept: vertex taken when in_valid && in_ready. in_ready = (state==COLLECT) && rst_n.
//  Mode: sampled as cur_mode on accept when vcnt==0; ignored mid-primitive.
//  vcnt counts vertices in the current primitive, saturates at 3 (list resets to 0 per tri).
//  Formation (new vertex N, prior A, B):
//   - list: A, B, N form tri (A,B,N) on every 3rd vertex; then vcnt=0.
//   - strip: from 3rd vertex on; parity 0 -> (A,B,N), parity 1 -> (B,A,N); then A<=B, B<=N, parity^=1.
//   - fan: A is pivot, fixed; tri (A,B,N); then B<=N.
//   - Parity clears at primitive start.
//  FSM:
//   - COLLECT -> ISSUE on accept completing a triangle; setup_v* latched that cycle.
//   - ISSUE: if !setup_busy, setup_start=1 for exactly one cycle -> WAIT; else hold in ISSUE.
//   - WAIT: on setup_done -> COLLECT, tri_count++.
//   - setup_done outside WAIT is ignored.
//  Latency: completing vertex accepted cycle N -> setup_start at N+1 if setup idle.
//   in_ready returns the cycle after setup_done.
//  setup_v0..v2 are stable from the latch cycle through the setup_done cycle (setup reads them for multiple cycles).
//  in_last: on the accepting cycle, after any triangle formation, vcnt=0 and parity=0.
//   - If no triangle formed from the current primitive's leftover vertices, drop_count += vcnt.
//   - Leftover = list: vcnt mod 3; strip/fan with fewer than 3 vertices.
//   - A completing in_last vertex still issues its triangle.
//  Counters wrap at 2^COUNT_W without saturation.
//  Simultaneous: setup_done and a new in_valid in the same cycle -> vertex not accepted that cycle (in_ready=0).
//  Reset mid-operation (ISSUE/WAIT): returns to COLLECT immediately; partial buffer lost; no start pulse.
// CONFIGURATION
//  TRI_ASM_DEGEN_DROP_EN defined:
//   - A formed triangle with any two vertices having equal x and y is not issued.
//   - FSM stays in COLLECT; tri_count unchanged; drop_count += 1.
//   - Strip/fan buffer shift and parity toggle still occur.
//  Undefined: all formed triangles are issued; degenerate rejection is left to setup.valid.
// TESTING
//  1. List mode, 6 vertices, setup done 5 cycles after start -> 2 setup_start pulses.
//     - v* = (V0,V1,V2), (V3,V4,V5); tri_count=2.
//  2. Strip mode, 5 vertices, last on V4 -> 3 tris: (V0,V1,V2), (V2,V1,V3), (V2,V3,V4).
//     - Next primitive parity=0.
//  3. Fan mode, V0..V4 -> (V0,V1,V2), (V0,V2,V3), (V0,V3,V4); tri_count=3.
//  4. List mode, in_last on 2nd vertex -> no start; drop_count=2; next 3 vertices form one tri.
//  5. setup_busy held high 4 cycles in ISSUE -> setup_start delayed until busy low, single pulse.
//     - in_ready=0 throughout; v* stable.
//  6. rst_n low during WAIT -> setup_start=0, tri_count=0, in_ready=1 after release.
//     - With TRI_ASM_DEGEN_DROP_EN: list (1,1),(1,1),(5,2) -> no start, drop_count=1.

Source files
------------

// File: rtl/triangle_assembler.sv
// rtl/triangle_assembler.sv - assembles a vertex stream into list/strip/fan triangles for triangle setup
// Optional feature: TRI_ASM_DEGEN_DROP_EN rejects triangles with two vertices sharing x and y.
package tri_asm_pkg;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } vertex_t;
endpackage

module triangle_assembler
  import tri_asm_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  vertex_t            in_vertex,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  input  logic [1:0]         mode,
  output vertex_t            setup_v0,
  output vertex_t            setup_v1,
  output vertex_t            setup_v2,
  output logic               setup_start,
  input  logic               setup_busy,
  input  logic               setup_done,
  output logic [COUNT_W-1:0] tri_count,
  output logic [COUNT_W-1:0] drop_count
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         vcnt_q, vcnt_d;
  logic               parity_q, parity_d;
  logic [1:0]         cur_mode_q, cur_mode_d;
  vertex_t            a_q, a_d, b_q, b_d;
  vertex_t            v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
  logic [COUNT_W-1:0] tri_count_q, tri_count_d;
  logic [COUNT_W-1:0] drop_count_q, drop_count_d;

  logic       accept;
  logic [1:0] eff_mode;
  logic       is_strip, is_fan, is_list;
  logic [1:0] vcnt_inc;
  logic       form, swap, degen, issue;
  vertex_t    t0, t1;

  assign in_ready = (state_q == S_COLLECT) && rst_n;
  assign accept   = in_valid && in_ready;

  // Mode only matters at primitive start; mid-primitive changes are ignored.
  assign eff_mode = (vcnt_q == 2'd0) ? mode : cur_mode_q;
  assign is_strip = (eff_mode == 2'b01);
  assign is_fan   = (eff_mode == 2'b10);
  assign is_list  = !is_strip && !is_fan;
  assign vcnt_inc = (vcnt_q == 2'd3) ? 2'd3 : vcnt_q + 2'd1;
  assign form     = accept && (is_list ? (vcnt_q == 2'd2) : (vcnt_q >= 2'd2));
  assign swap     = is_strip && parity_q;
  assign t0       = swap ? b_q : a_q;
  assign t1       = swap ? a_q : b_q;

`ifdef TRI_ASM_DEGEN_DROP_EN
  assign degen = ((t0.x == t1.x) && (t0.y == t1.y)) ||
                 ((t0.x == in_vertex.x) && (t0.y == in_vertex.y)) ||
                 ((t1.x == in_vertex.x) && (t1.y == in_vertex.y));
`else
  assign degen = 1'b0;
`endif

  assign issue = form && !degen;

  always_comb begin
    state_d      = state_q;
    setup_start  = 1'b0;
    vcnt_d       = vcnt_q;
    parity_d     = parity_q;
    cur_mode_d   = cur_mode_q;
    a_d          = a_q;
    b_d          = b_q;
    v0_d         = v0_q;
    v1_d         = v1_q;
    v2_d         = v2_q;
    tri_count_d  = tri_count_q;
    drop_count_d = drop_count_q;

    if (accept) begin
      if (vcnt_q == 2'd0) begin
        a_d        = in_vertex;
        cur_mode_d = mode;
        parity_d   = 1'b0;
      end else if (vcnt_q == 2'd1) begin
        b_d = in_vertex;
      end else if (is_strip) begin
        a_d      = b_q;
        b_d      = in_vertex;
        parity_d = !parity_q;
      end else if (is_fan) begin
        b_d = in_vertex;
      end

      vcnt_d = (is_list && (vcnt_q == 2'd2)) ? 2'd0 : vcnt_inc;

      if (in_last) begin
        vcnt_d   = 2'd0;
        parity_d = 1'b0;
        if (!form) begin
          drop_count_d = drop_count_q + COUNT_W'(vcnt_inc);
        end
      end

      if (form && degen) begin
        drop_count_d = drop_count_q + COUNT_W'(1);
      end
    end

    case (state_q)
      S_COLLECT: begin
        if (issue) begin
          state_d = S_ISSUE;
          v0_d    = t0;
          v1_d    = t1;
          v2_d    = in_vertex;
        end
      end
      S_ISSUE: begin
        if (!setup_busy) begin
          setup_start = 1'b1;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (setup_done) begin
          state_d     = S_COLLECT;
          tri_count_d = tri_count_q + COUNT_W'(1);
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_COLLECT;
      vcnt_q       <= 2'd0;
      parity_q     <= 1'b0;
      cur_mode_q   <= 2'b00;
      a_q          <= '0;
      b_q          <= '0;
      v0_q         <= '0;
      v1_q         <= '0;
      v2_q         <= '0;
      tri_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      vcnt_q       <= vcnt_d;
      parity_q     <= parity_d;
      cur_mode_q   <= cur_mode_d;
      a_q          <= a_d;
      b_q          <= b_d;
      v0_q         <= v0_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      tri_count_q  <= tri_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign setup_v0   = v0_q;
  assign setup_v1   = v1_q;
  assign setup_v2   = v2_q;
  assign tri_count  = tri_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_triangle_assembler.sv
// tb/tb_triangle_assembler.sv - directed self-checking bench for triangle_assembler
// Degenerate-drop scenario is selected by TRI_ASM_DEGEN_DROP_EN.
module tb_triangle_assembler;
  import tri_asm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  vertex_t     in_vertex = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [1:0]  mode = 2'b00;
  vertex_t     setup_v0, setup_v1, setup_v2;
  logic        setup_start;
  logic        setup_busy, setup_done;
  logic [15:0] tri_count, drop_count;

  logic resp_busy = 1'b0, man_busy = 1'b0, resp_done = 1'b0, man_done = 1'b0;
  assign setup_busy = resp_busy | man_busy;
  assign setup_done = resp_done | man_done;

  int pass_cnt = 0;
  int total_cnt = 0;
  int start_cycles = 0;
  int stable_err = 0;
  bit auto_en = 1'b0;
  bit resp_active = 1'b0;
  logic [143:0] tri_q[$];
  logic [143:0] resp_cap;

  triangle_assembler #(.COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_vertex(in_vertex), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .mode(mode),
    .setup_v0(setup_v0), .setup_v1(setup_v1), .setup_v2(setup_v2),
    .setup_start(setup_start), .setup_busy(setup_busy), .setup_done(setup_done),
    .tri_count(tri_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (setup_start) start_cycles++;

  // Setup model: busy from the cycle after start, done four cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_en && setup_start) begin
        resp_active = 1'b1;
        resp_cap = {setup_v0, setup_v1, setup_v2};
        tri_q.push_back(resp_cap);
        @(posedge clk);
        #1 resp_busy = 1'b1;
        repeat (4) @(negedge clk);
        if ({setup_v0, setup_v1, setup_v2} !== resp_cap) stable_err++;
        resp_done = 1'b1;
        @(negedge clk);
        resp_done = 1'b0;
        resp_busy = 1'b0;
        resp_active = 1'b0;
      end
    end
  end

  function automatic vertex_t mkv(input int i);
    vertex_t v;
    v.x = 16'(100 + i);
    v.y = 16'(200 + i);
    v.z = 16'(300 + i);
    return v;
  endfunction

  function automatic vertex_t mkxy(input int x, input int y, input int z);
    vertex_t v;
    v.x = 16'(x);
    v.y = 16'(y);
    v.z = 16'(z);
    return v;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input vertex_t v, input logic last);
    int n = 0;
    in_vertex = v;
    in_valid  = 1'b1;
    in_last   = last;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total_cnt++;
      $display("FAIL send_timeout in_ready got %b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_tris(input int n);
    int k = 0;
    while (!(tri_q.size() >= n && !resp_active && in_ready) && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) begin
      total_cnt++;
      $display("FAIL wait_tris_timeout got %0d tris required %0d", tri_q.size(), n);
    end
  endtask

  task automatic check_tris(input string name, input logic [143:0] exp[$]);
    logic [143:0] got;
    foreach (exp[i]) begin
      total_cnt++;
      got = (tri_q.size() > 0) ? tri_q.pop_front() : '0;
      if (got !== exp[i]) $display("FAIL %s_tri%0d got %h required %h", name, i, got, exp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b required 0", in_ready); else pass_cnt++;
    total_cnt++; if (setup_start !== 1'b0) $display("FAIL reset_start got %b required 0", setup_start); else pass_cnt++;
    total_cnt++; if (tri_count !== 16'd0) $display("FAIL reset_tri_count got %0d required 0", tri_count); else pass_cnt++;
    total_cnt++; if (drop_count !== 16'd0) $display("FAIL reset_drop_count got %0d required 0", drop_count); else pass_cnt++;
    total_cnt++; if ({setup_v0, setup_v1, setup_v2} !== 144'd0) $display("FAIL reset_setup_v got %h required 0", {setup_v0, setup_v1, setup_v2}); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready got %b required 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_list;
    logic [143:0] exp[$];
    int s0 = start_cycles;
    auto_en = 1'b1; mode = 2'b00; tri_q.delete();
    for (int i = 0; i < 6; i++) send(mkv(i), 1'b0);
    wait_tris(2);
    exp = '{{mkv(0), mkv(1), mkv(2)}, {mkv(3), mkv(4), mkv(5)}};
    check_tris("list", exp);
    total_cnt++; if (start_cycles - s0 !== 2) $display("FAIL list_starts got %0d required 2", start_cycles - s0); else pass_cnt++;
    total_cnt++; if (tri_count !== 16'd2) $display("FAIL list_tri_count got %0d required 2", tri_count); else pass_cnt++;
    total_cnt++; if (stable_err !== 0) $display("FAIL list_v_stable got %0d errors required 0", stable_err); else pass_cnt++;
  endtask

  task automatic test_strip;
    logic [143:0] exp[$];
    mode = 2'b01; tri_q.delete();
    for (int i = 10; i < 15; i++) send(mkv(i), i == 14);
    wait_tris(3);
    exp = '{{mkv(10), mkv(11), mkv(12)}, {mkv(12), mkv(11), mkv(13)}, {mkv(12), mkv(13), mkv(14)}};
    check_tris("strip", exp);
    total_cnt++; if (tri_count !== 16'd5) $display("FAIL strip_tri_count got %0d required 5", tri_count); else pass_cnt++;
    total_cnt++; if (drop_count !== 16'd0) $display("FAIL strip_drop_count got %0d required 0", drop_count); else pass_cnt++;
    for (int i = 20; i < 23; i++) send(mkv(i), i == 22);
    wait_tris(1);
    exp = '{{mkv(20), mkv(21), mkv(22)}};
    check_tris("strip_parity_reset", exp);
  endtask

  task automatic test_fan;
    logic [143:0] exp[$];
    mode = 2'b10; tri_q.delete();
    send(mkv(30), 1'b0);
    mode = 2'b00;
    for (int i = 31; i < 35; i++) send(mkv(i), i == 34);
    wait_tris(3);
    exp = '{{mkv(30), mkv(31), mkv(32)}, {mkv(30), mkv(32), mkv(33)}, {mkv(30), mkv(33), mkv(34)}};
    check_tris("fan", exp);
    total_cnt++; if (tri_count !== 16'd9) $display("FAIL fan_tri_count got %0d required 9", tri_count); else pass_cnt++;
  endtask

  task automatic test_drop;
    logic [143:0] exp[$];
    int s0 = start_cycles;
    mode = 2'b00; tri_q.delete();
    send(mkv(40), 1'b0);
    send(mkv(41), 1'b1);
    repeat (3) @(negedge clk);
    total_cnt++; if (drop_count !== 16'd2) $display("FAIL drop_count got %0d required 2", drop_count); else pass_cnt++;
    total_cnt++; if (start_cycles - s0 !== 0) $display("FAIL drop_no_start got %0d required 0", start_cycles - s0); else pass_cnt++;
    for (int i = 42; i < 45; i++) send(mkv(i), 1'b0);
    wait_tris(1);
    exp = '{{mkv(42), mkv(43), mkv(44)}};
    check_tris("drop_next", exp);
    total_cnt++; if (tri_count !== 16'd10) $display("FAIL drop_tri_count got %0d required 10", tri_count); else pass_cnt++;
  endtask

  task automatic test_busy;
    logic [143:0] expv;
    int s0;
    auto_en = 1'b0; man_busy = 1'b1; mode = 2'b00;
    s0 = start_cycles;
    expv = {mkv(50), mkv(51), mkv(52)};
    for (int i = 50; i < 53; i++) send(mkv(i), 1'b0);
    for (int c = 0; c < 4; c++) begin
      total_cnt++;
      if (setup_start !== 1'b0 || in_ready !== 1'b0 || {setup_v0, setup_v1, setup_v2} !== expv)
        $display("FAIL busy_hold%0d start=%b in_ready=%b v=%h required start=0 in_ready=0 v=%h",
                 c, setup_start, in_ready, {setup_v0, setup_v1, setup_v2}, expv);
      else pass_cnt++;
      @(negedge clk);
    end
    @(posedge clk);
    #1 man_busy = 1'b0;
    @(negedge clk);
    total_cnt++; if (setup_start !== 1'b1) $display("FAIL busy_release_start got %b required 1", setup_start); else pass_cnt++;
    @(posedge clk);
    #1 man_busy = 1'b1;
    @(negedge clk);
    total_cnt++; if (setup_start !== 1'b0) $display("FAIL busy_single_pulse got %b required 0", setup_start); else pass_cnt++;
    total_cnt++; if ({setup_v0, setup_v1, setup_v2} !== expv) $display("FAIL busy_wait_v got %h required %h", {setup_v0, setup_v1, setup_v2}, expv); else pass_cnt++;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0; man_busy = 1'b0;
    total_cnt++; if (tri_count !== 16'd11) $display("FAIL busy_tri_count got %0d required 11", tri_count); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL busy_in_ready_back got %b required 1", in_ready); else pass_cnt++;
    total_cnt++; if (start_cycles - s0 !== 1) $display("FAIL busy_starts got %0d required 1", start_cycles - s0); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int k = 0;
    auto_en = 1'b0; mode = 2'b00;
    for (int i = 60; i < 63; i++) send(mkv(i), 1'b0);
    while (!setup_start && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!setup_start) begin
      total_cnt++;
      $display("FAIL rstmid_start_timeout got %b required 1", setup_start);
    end
    @(posedge clk);
    #1 man_busy = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++; if (setup_start !== 1'b0) $display("FAIL rstmid_start got %b required 0", setup_start); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL rstmid_in_ready got %b required 0", in_ready); else pass_cnt++;
    total_cnt++; if (tri_count !== 16'd0) $display("FAIL rstmid_tri_count got %0d required 0", tri_count); else pass_cnt++;
    total_cnt++; if (drop_count !== 16'd0) $display("FAIL rstmid_drop_count got %0d required 0", drop_count); else pass_cnt++;
    man_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++; if (in_ready !== 1'b1 || setup_start !== 1'b0)
      $display("FAIL rstmid_release in_ready=%b start=%b required in_ready=1 start=0", in_ready, setup_start);
    else pass_cnt++;
  endtask

  task automatic test_degen;
    int s0 = start_cycles;
    auto_en = 1'b1; mode = 2'b00; tri_q.delete();
    send(mkxy(1, 1, 0), 1'b0);
    send(mkxy(1, 1, 1), 1'b0);
    send(mkxy(5, 2, 2), 1'b0);
`ifdef TRI_ASM_DEGEN_DROP_EN
    repeat (4) @(negedge clk);
    total_cnt++; if (start_cycles - s0 !== 0) $display("FAIL degen_no_start got %0d required 0", start_cycles - s0); else pass_cnt++;
    total_cnt++; if (drop_count !== 16'd1) $display("FAIL degen_drop_count got %0d required 1", drop_count); else pass_cnt++;
    total_cnt++; if (tri_count !== 16'd0) $display("FAIL degen_tri_count got %0d required 0", tri_count); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL degen_in_ready got %b required 1", in_ready); else pass_cnt++;
`else
    wait_tris(1);
    total_cnt++; if (start_cycles - s0 !== 1) $display("FAIL degen_issued_starts got %0d required 1", start_cycles - s0); else pass_cnt++;
    total_cnt++; if (tri_count !== 16'd1) $display("FAIL degen_issued_tri_count got %0d required 1", tri_count); else pass_cnt++;
    total_cnt++; if (drop_count !== 16'd0) $display("FAIL degen_issued_drop_count got %0d required 0", drop_count); else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_list();
    test_strip();
    test_fan();
    test_drop();
    test_busy();
    test_reset_mid();
    test_degen();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
